// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: character width, line start
// level and the transmit-queue handshake states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 7;

  // Line level of the start bit; the uart serialiser drives this before data.
  localparam logic START_SIG = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a combinational head-of-queue read port.
module sync_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  // A write while full is refused even when a pop frees a slot on the same edge.
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign full    = (r_count == (AW + 1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Queued feeder for the uart send/send_data/sent handshake: buffers characters,
// issues one at a time and abandons a character if completion never arrives.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = UART_DATA_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   send,
  output logic [DATA_W-1:0]      send_data,
  input  logic                   sent,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [DATA_W-1:0] r_send_data;
  logic [DATA_W-1:0] w_head;
  logic [TW-1:0]     r_tmr;
  logic              r_sent_q;
  logic              r_done;
  logic              r_timeout;
  logic              r_overflow;
  logic              w_rise;
  logic              w_pop;
  logic              w_done_nxt;
  logic              w_to_nxt;
  logic              w_tmr_clr;
  logic              w_tmr_inc;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Edge-detect so a level-style sent completes only one character.
  assign w_rise = sent && !r_sent_q;

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_done_nxt = 1'b0;
    w_to_nxt   = 1'b0;
    w_tmr_clr  = 1'b0;
    w_tmr_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty) begin
          w_pop  = 1'b1;
          w_next = PULSE;
        end
      end
      PULSE: begin
        w_tmr_clr = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (w_rise) begin
          w_done_nxt = 1'b1;
          w_next     = IDLE;
        end else if (r_tmr == TMR_LAST) begin
          w_to_nxt = 1'b1;
          w_next   = IDLE;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_send_data <= '0;
      r_tmr       <= '0;
      r_sent_q    <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sent_q  <= sent;
      r_done    <= w_done_nxt;
      r_timeout <= w_to_nxt;
      if (wr_en && full) r_overflow <= 1'b1;
      if (w_pop) r_send_data <= w_head;
      if (w_tmr_clr)      r_tmr <= '0;
      else if (w_tmr_inc) r_tmr <= r_tmr + 1'b1;
    end
  end

  assign send        = (r_state == PULSE);
  assign busy        = (r_state != IDLE);
  assign send_data   = r_send_data;
  assign done        = r_done;
  assign timeout_err = r_timeout;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a behavioural uart responder logs every
// send/done/timeout event by cycle; each scenario task checks those logs against expectations.
module tb_uart_tx_queue;

  localparam int unsigned DW    = 7;
  localparam int unsigned DEPTH = 8;
  localparam int          TMO   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          send;
  logic [DW-1:0] send_data;
  logic          sent;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  uart_tx_queue #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .send        (send),
    .send_data   (send_data),
    .sent        (sent),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart responder: 0 = sent held low, 1 = one-cycle sent pulse sent_lat cycles after
  // each send, 2 = sent goes high sent_lat cycles after the first send and stays high.
  int            sent_mode = 0;
  int            sent_lat  = 10;
  int            cd        = 0;
  logic          prev_send = 1'b0;
  logic [DW-1:0] got_q[$];
  int            send_cyc[$];
  int            done_cyc[$];
  int            to_cyc[$];
  int            n_long    = 0;
  int            n_both    = 0;

  initial begin
    sent = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (send) begin
        got_q.push_back(send_data);
        send_cyc.push_back(cyc);
      end
      if (send && prev_send) n_long++;
      prev_send = send;
      if (done) done_cyc.push_back(cyc);
      if (timeout_err) to_cyc.push_back(cyc);
      if (done && timeout_err) n_both++;
      if (sent_mode == 0) begin
        sent = 1'b0;
        cd   = 0;
      end else begin
        if (sent_mode == 1 && sent) sent = 1'b0;
        if (send) cd = sent_lat;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) sent = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cyc.size() + to_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    sent_mode = 0;
    wr_en     = 1'b0;
    wr_data   = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    obs = {send, busy, done, timeout_err, full, overflow, empty, count, send_data};
    total++;
    if (obs !== {6'b0, 1'b1, 4'd0, 7'd0}) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, {6'b0, 1'b1, 4'd0, 7'd0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hello();
    logic [DW-1:0] msg [5];
    int bs, bd, bt, c0;
    bit ok;
    msg = '{7'h48, 7'h65, 7'h6C, 7'h6C, 7'h6F};
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 1; sent_lat = 10;
    c0 = cyc;
    for (int i = 0; i < 5; i++) push(msg[i]);
    wait_events(bd + bt + 5, 300, ok);
    @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL hello_wait: got timeout want 5 completions"); end
    total++; if (got_q.size() - bs !== 5) begin bad++; $display("FAIL hello_sends: got %0d want 5", got_q.size() - bs); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_q[bs+i] !== msg[i]) begin bad++; $display("FAIL hello_data[%0d]: got %h want %h", i, got_q[bs+i], msg[i]); end
    end
    total++; if (send_cyc[bs] !== c0 + 2) begin bad++; $display("FAIL hello_first_latency: got %0d want %0d", send_cyc[bs], c0 + 2); end
    total++; if (done_cyc.size() - bd !== 5) begin bad++; $display("FAIL hello_done: got %0d want 5", done_cyc.size() - bd); end
    total++; if (to_cyc.size() - bt !== 0) begin bad++; $display("FAIL hello_timeouts: got %0d want 0", to_cyc.size() - bt); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (done_cyc[bd+i] !== send_cyc[bs+i] + sent_lat + 1) begin
        bad++; $display("FAIL hello_done_cycle[%0d]: got %0d want %0d", i, done_cyc[bd+i], send_cyc[bs+i] + sent_lat + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (send_cyc[bs+i+1] !== done_cyc[bd+i] + 1) begin
        bad++; $display("FAIL hello_next_send[%0d]: got %0d want %0d", i, send_cyc[bs+i+1], done_cyc[bd+i] + 1);
      end
    end
    total++; if ({empty, busy} !== 2'b10) begin bad++; $display("FAIL hello_end_state: got %b want 10", {empty, busy}); end
    total++; if (n_long !== 0 || n_both !== 0) begin bad++; $display("FAIL hello_pulse_shape: got long=%0d both=%0d want 0 0", n_long, n_both); end
  endtask

  task automatic test_simul();
    logic [DW-1:0] a, b;
    int bs, bd, bt;
    bit ok;
    a = DW'($urandom); b = DW'($urandom);
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 1; sent_lat = 3;
    push(a);
    push(b);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL simul_count: got %0d want 1", count); end
    wait_events(bd + bt + 2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL simul_wait: got timeout want 2 completions"); end
    total++;
    if (got_q[bs] !== a || got_q[bs+1] !== b) begin
      bad++; $display("FAIL simul_order: got %h %h want %h %h", got_q[bs], got_q[bs+1], a, b);
    end
    total++; if (done_cyc.size() - bd !== 2) begin bad++; $display("FAIL simul_done: got %0d want 2", done_cyc.size() - bd); end
  endtask

  task automatic test_timeout();
    int bs, bd, bt;
    bit ok;
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 0;
    push(7'h31);
    push(7'h32);
    wait_events(bd + bt + 2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_wait: got no timeouts want 2"); end
    total++; if (to_cyc.size() - bt !== 2) begin bad++; $display("FAIL timeout_count: got %0d want 2", to_cyc.size() - bt); end
    total++; if (done_cyc.size() - bd !== 0) begin bad++; $display("FAIL timeout_no_done: got %0d want 0", done_cyc.size() - bd); end
    total++;
    if (to_cyc[bt] !== send_cyc[bs] + TMO + 1) begin
      bad++; $display("FAIL timeout_cycle0: got %0d want %0d", to_cyc[bt], send_cyc[bs] + TMO + 1);
    end
    total++;
    if (send_cyc[bs+1] !== to_cyc[bt] + 1) begin
      bad++; $display("FAIL timeout_next_send: got %0d want %0d", send_cyc[bs+1], to_cyc[bt] + 1);
    end
    total++;
    if (to_cyc[bt+1] !== send_cyc[bs+1] + TMO + 1) begin
      bad++; $display("FAIL timeout_cycle1: got %0d want %0d", to_cyc[bt+1], send_cyc[bs+1] + TMO + 1);
    end
    total++;
    if (got_q[bs] !== 7'h31 || got_q[bs+1] !== 7'h32) begin
      bad++; $display("FAIL timeout_data: got %h %h want 31 32", got_q[bs], got_q[bs+1]);
    end
  endtask

  task automatic test_level();
    int bs, bd, bt;
    bit ok;
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 2; sent_lat = 4;
    push(7'h55);
    push(7'h2A);
    wait_events(bd + bt + 2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL level_wait: got timeout want 2 events"); end
    total++; if (done_cyc.size() - bd !== 1) begin bad++; $display("FAIL level_done: got %0d want 1", done_cyc.size() - bd); end
    total++; if (to_cyc.size() - bt !== 1) begin bad++; $display("FAIL level_timeout: got %0d want 1", to_cyc.size() - bt); end
    total++;
    if (to_cyc[bt] !== send_cyc[bs+1] + TMO + 1) begin
      bad++; $display("FAIL level_timeout_cycle: got %0d want %0d", to_cyc[bt], send_cyc[bs+1] + TMO + 1);
    end
    sent_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] c [10];
    int bs, bd, bt;
    bit ok;
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 0;
    for (int i = 0; i < 10; i++) c[i] = DW'($urandom);
    for (int i = 0; i < 10; i++) push(c[i]);
    total++;
    if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
      bad++; $display("FAIL overflow_state: got count=%0d full=%b ovf=%b want 8 1 1", count, full, overflow);
    end
    total++; if (send_data !== c[0]) begin bad++; $display("FAIL overflow_inflight: got %h want %h", send_data, c[0]); end
    repeat (3) @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
    wait_events(bd + bt + 9, 250, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL overflow_drain_wait: got timeout want 9 events"); end
    total++; if (got_q.size() - bs !== 9) begin bad++; $display("FAIL overflow_sends: got %0d want 9", got_q.size() - bs); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got_q[bs+i] !== c[i]) begin bad++; $display("FAIL overflow_order[%0d]: got %h want %h", i, got_q[bs+i], c[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky_end: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int bs, bd, bt;
    bit ok;
    sent_mode = 0;
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    repeat (3) @(negedge clk);
    total++; if ({busy, count} !== {1'b1, 4'd3}) begin bad++; $display("FAIL midreset_pre: got busy=%b count=%0d want 1 3", busy, count); end
    rst = 1'b1;
    #1;
    total++;
    if ({send, busy, overflow, count, empty} !== {3'b000, 4'd0, 1'b1}) begin
      bad++; $display("FAIL midreset_immediate: got send=%b busy=%b ovf=%b count=%0d empty=%b want 0 0 0 0 1",
                      send, busy, overflow, count, empty);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 1; sent_lat = 5;
    push(7'h42);
    wait_events(bd + bt + 1, 60, ok);
    repeat (5) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL midreset_wait: got timeout want 1 completion"); end
    total++; if (got_q.size() - bs !== 1) begin bad++; $display("FAIL midreset_sends: got %0d want 1", got_q.size() - bs); end
    total++; if (got_q[bs] !== 7'h42) begin bad++; $display("FAIL midreset_data: got %h want 42", got_q[bs]); end
    total++; if (done_cyc.size() - bd !== 1) begin bad++; $display("FAIL midreset_done: got %0d want 1", done_cyc.size() - bd); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    int bs, bd, bt, pushed, stored;
    bit ok;
    bs = got_q.size(); bd = done_cyc.size(); bt = to_cyc.size();
    sent_mode = 1; sent_lat = $urandom_range(2, 8);
    pushed = 0;
    while (pushed < 30) begin
      stored = pushed - (got_q.size() - bs);
      total++;
      if (count !== 4'(stored)) begin bad++; $display("FAIL random_count: got %0d want %0d", count, stored); end
      if ($urandom_range(0, 2) != 0 && stored < DEPTH) begin
        d = DW'($urandom);
        exp_q.push_back(d);
        push(d);
        pushed++;
      end else begin
        @(negedge clk);
      end
    end
    wait_events(bd + bt + 30, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL random_wait: got timeout want 30 completions"); end
    total++; if (got_q.size() - bs !== 30) begin bad++; $display("FAIL random_sends: got %0d want 30", got_q.size() - bs); end
    for (int i = 0; i < 30; i++) begin
      total++;
      if (got_q[bs+i] !== exp_q[i]) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", i, got_q[bs+i], exp_q[i]); end
    end
    total++; if (done_cyc.size() - bd !== 30) begin bad++; $display("FAIL random_done: got %0d want 30", done_cyc.size() - bd); end
    total++; if (to_cyc.size() - bt !== 0) begin bad++; $display("FAIL random_timeouts: got %0d want 0", to_cyc.size() - bt); end
    total++; if ({overflow, empty, busy} !== 3'b010) begin bad++; $display("FAIL random_end_state: got %b want 010", {overflow, empty, busy}); end
    total++; if (n_long !== 0 || n_both !== 0) begin bad++; $display("FAIL random_pulse_shape: got long=%0d both=%0d want 0 0", n_long, n_both); end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    test_reset();
    test_hello();
    test_simul();
    test_timeout();
    test_level();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
